// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor with a running accumulator,
// saturating or wrapping overflow, and valid/ready flow control on both sides.
module sm_addsub_pipe #(
  parameter int W   = 32,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W:0]   a,
  input  logic [W:0]   b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   y,
  output logic         ovf
);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  // Clears the sign of a zero magnitude so -0 never enters or leaves the block.
  function automatic logic [W:0] canon(input logic [W:0] v);
    canon = {v[W] & (|v[W-1:0]), v[W-1:0]};
  endfunction

  logic         s1_valid_q, s1_valid_d;
  op_e          s1_op_q,    s1_op_d;
  logic [W:0]   s1_a_q,     s1_a_d;
  logic [W:0]   s1_b_q,     s1_b_d;
  logic         out_valid_q, out_valid_d;
  logic [W:0]   y_q,        y_d;
  logic         ovf_q,      ovf_d;
  logic [W:0]   acc_q,      acc_d;

  logic         accept;
  logic         advance;

  logic [W:0]   x_op;
  logic [W:0]   y_op;
  logic [W:0]   sum;
  logic [W-1:0] mag;
  logic         sgn;
  logic [W:0]   res;
  logic         res_ovf;

  assign in_ready = !rst & (!s1_valid_q | !out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign advance  = s1_valid_q & (!out_valid_q | out_ready);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring latches.
  always_comb begin
    x_op    = canon(s1_a_q);
    y_op    = canon(s1_b_q);
    sum     = '0;
    mag     = '0;
    sgn     = 1'b0;
    res     = '0;
    res_ovf = 1'b0;

    case (s1_op_q)
      OP_SUB: y_op[W] = ~y_op[W];
      OP_ACC: begin
        x_op = acc_q;
        y_op = canon(s1_a_q);
      end
      default: ;
    endcase

    if (s1_op_q == OP_LOAD) begin
      res = canon(s1_a_q);
    end else begin
      if (x_op[W] == y_op[W]) begin
        sum     = {1'b0, x_op[W-1:0]} + {1'b0, y_op[W-1:0]};
        res_ovf = sum[W];
        mag     = (SAT && sum[W]) ? {W{1'b1}} : sum[W-1:0];
        sgn     = x_op[W];
      end else if ({1'b0, x_op[W-1:0]} >= {1'b0, y_op[W-1:0]}) begin
        sum = {1'b0, x_op[W-1:0]} - {1'b0, y_op[W-1:0]};
        mag = sum[W-1:0];
        sgn = x_op[W];
      end else begin
        sum = {1'b0, y_op[W-1:0]} - {1'b0, x_op[W-1:0]};
        mag = sum[W-1:0];
        sgn = y_op[W];
      end
      res = canon({sgn, mag});
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op_e'(op);
      s1_a_d     = a;
      s1_b_d     = b;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    // The accumulator is written at the same boundary where the next ACC reads
    // it, so back-to-back ACC ops chain with no bubble.
    if (advance) begin
      out_valid_d = 1'b1;
      y_d         = res;
      ovf_d       = res_ovf;
      if (s1_op_q == OP_ACC || s1_op_q == OP_LOAD) acc_d = res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed bench for sm_addsub_pipe (W=8): a saturating and a wrapping
// instance share stimulus; expected values are hand-computed constants.
module tb_sm_addsub_pipe;

  localparam int W = 8;

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] ACC  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [1:0]   in_op;
  logic [W:0]   in_a;
  logic [W:0]   in_b;
  logic         out_ready;

  logic         in_ready1, out_valid1, ovf1;
  logic [W:0]   y1;
  logic         in_ready0, out_valid0, ovf0;
  logic [W:0]   y0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sm_addsub_pipe #(.W(W), .SAT(1'b1)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .op        (in_op),
    .a         (in_a),
    .b         (in_b),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .y         (y1),
    .ovf       (ovf1)
  );

  sm_addsub_pipe #(.W(W), .SAT(1'b0)) dut_wrap (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .op        (in_op),
    .a         (in_a),
    .b         (in_b),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .y         (y0),
    .ovf       (ovf0)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [W:0] av, input logic [W:0] bv);
    in_op = o;
    in_a  = av;
    in_b  = bv;
  endtask

  // One isolated beat with out_ready high: checks latency, result and drain.
  task automatic run_one(input string tag, input logic [1:0] o,
                         input logic [W:0] av, input logic [W:0] bv,
                         input logic [W:0] exp_sat, input logic [W:0] exp_wrap,
                         input logic exp_ovf);
    drive(o, av, bv);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, 16'(in_ready1), 16'd1);
    step();
    in_valid = 1'b0;
    check({tag, ".early_valid"}, 16'(out_valid1), 16'd0);
    step();
    check({tag, ".out_valid"}, 16'(out_valid1), 16'd1);
    check({tag, ".y_sat"},     16'(y1),         16'(exp_sat));
    check({tag, ".ovf_sat"},   16'(ovf1),       16'(exp_ovf));
    check({tag, ".y_wrap"},    16'(y0),         16'(exp_wrap));
    check({tag, ".ovf_wrap"},  16'(ovf0),       16'(exp_ovf));
    step();
    check({tag, ".drained"},   16'(out_valid1), 16'd0);
  endtask

  logic [1:0] bp_op [3];
  logic [W:0] bp_a  [3];
  int         idx;
  logic       will_accept;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(ADD, '0, '0);
    step();
    step();
    check("rst.in_ready",  16'(in_ready1),  16'd0);
    check("rst.out_valid", 16'(out_valid1), 16'd0);
    check("rst.y",         16'(y1),         16'd0);
    check("rst.ovf",       16'(ovf1),       16'd0);
    rst = 1'b0;
    #1;
    check("rst.release_ready", 16'(in_ready1), 16'd1);

    // Mixed signs, zero handling, overflow in both modes.
    run_one("mixed",     ADD, 9'h105, 9'h003, 9'h102, 9'h102, 1'b0);
    run_one("mixed_rev", ADD, 9'h003, 9'h105, 9'h102, 9'h102, 1'b0);
    run_one("sub_eq",    SUB, 9'h003, 9'h003, 9'h000, 9'h000, 1'b0);
    run_one("sub_neg",   SUB, 9'h105, 9'h105, 9'h000, 9'h000, 1'b0);
    run_one("neg_zero",  ADD, 9'h100, 9'h100, 9'h000, 9'h000, 1'b0);
    run_one("ovf_pos",   ADD, 9'h0C8, 9'h064, 9'h0FF, 9'h02C, 1'b1);
    run_one("ovf_neg",   ADD, 9'h1C8, 9'h164, 9'h1FF, 9'h12C, 1'b1);

    // Back-to-back accumulator chain at full rate.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(LOAD, 9'h00A, 9'h0AA);
    step();
    drive(ACC, 9'h119, 9'h0AA);
    step();
    check("acc.load_valid", 16'(out_valid1), 16'd1);
    check("acc.load_y",     16'(y1),         16'h00A);
    drive(ACC, 9'h00F, 9'h0AA);
    step();
    check("acc.neg_y",      16'(y1),         16'h10F);
    drive(ACC, 9'h000, 9'h0AA);
    step();
    check("acc.zero_y",     16'(y1),         16'h000);
    in_valid = 1'b0;
    step();
    check("acc.zero2_valid", 16'(out_valid1), 16'd1);
    check("acc.zero2_y",     16'(y1),         16'h000);
    step();
    run_one("acc_is_zero", ACC, 9'h003, 9'h000, 9'h003, 9'h003, 1'b0);

    // Backpressure: two beats fill the pipe, the third waits for out_ready.
    bp_op[0] = LOAD; bp_a[0] = 9'h005;
    bp_op[1] = ACC;  bp_a[1] = 9'h003;
    bp_op[2] = ACC;  bp_a[2] = 9'h004;
    idx       = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(bp_op[idx], bp_a[idx], 9'h000);
      #1;
      will_accept = in_ready1;
      step();
      if (will_accept) idx++;
    end
    check("bp.accepted",  16'(idx),        16'd2);
    check("bp.in_ready",  16'(in_ready1),  16'd0);
    check("bp.out_valid", 16'(out_valid1), 16'd1);
    check("bp.head_y",    16'(y1),         16'h005);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp.stall_y",     16'(y1),         16'h005);
      check("bp.stall_ready", 16'(in_ready1),  16'd0);
    end
    drive(bp_op[2], bp_a[2], 9'h000);
    out_ready = 1'b1;
    #1;
    check("bp.ready_rises", 16'(in_ready1), 16'd1);
    step();
    in_valid = 1'b0;
    check("bp.second_valid", 16'(out_valid1), 16'd1);
    check("bp.second_y",     16'(y1),         16'h008);
    step();
    check("bp.third_valid",  16'(out_valid1), 16'd1);
    check("bp.third_y",      16'(y1),         16'h00C);
    step();
    check("bp.empty",        16'(out_valid1), 16'd0);

    // Reset with both stages full must discard the beats and clear acc.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(LOAD, 9'h032, 9'h000);
    step();
    drive(ACC, 9'h014, 9'h000);
    step();
    in_valid = 1'b0;
    check("mid.full_valid", 16'(out_valid1), 16'd1);
    check("mid.full_y",     16'(y1),         16'h032);
    rst = 1'b1;
    #1;
    check("mid.rst_ready",  16'(in_ready1),  16'd0);
    step();
    rst = 1'b0;
    check("mid.out_valid",  16'(out_valid1), 16'd0);
    check("mid.y",          16'(y1),         16'h000);
    check("mid.ovf",        16'(ovf1),       16'd0);
    step();
    check("mid.no_ghost",   16'(out_valid1), 16'd0);
    run_one("mid_acc", ACC, 9'h007, 9'h000, 9'h007, 9'h007, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
